// File: rtl/bus_interface_unit_if.sv
// Core-side request/response and external multiplexed-bus signals of the bus interface unit.
// The slave modport is the unit's view; master is the view of whoever drives the core and memory side.
interface bus_interface_unit_if;
  logic       req;
  logic       rw;
  logic [7:0] addr_hi;
  logic [7:0] addr_lo;
  logic [7:0] wdata;
  logic [7:0] bus_in;
  logic       mem_rdy;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       ale_hi;
  logic       ale_lo;
  logic       oe_n;
  logic       we_n;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       err;

  modport slave (
    input  req, rw, addr_hi, addr_lo, wdata, bus_in, mem_rdy,
    output bus_out, bus_oe, ale_hi, ale_lo, oe_n, we_n, rdata, busy, done, err
  );

  modport master (
    output req, rw, addr_hi, addr_lo, wdata, bus_in, mem_rdy,
    input  bus_out, bus_oe, ale_hi, ale_lo, oe_n, we_n, rdata, busy, done, err
  );
endinterface

// File: rtl/bus_interface_unit.sv
// Multiplexed-bus master: address high byte, address low byte, then a data phase that waits on
// mem_rdy with a bounded timeout. Every output is a flop loaded from the next-state decode.
module bus_interface_unit #(
  parameter int unsigned WAIT_MAX = 15
) (
  input logic                 clk,
  input logic                 rst_n,
  bus_interface_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ADDR_H, ADDR_L, DATA, DONE} state_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_MAX);

  state_t     state_q, state_d;
  logic       rw_q, rw_d;
  logic [7:0] addr_hi_q, addr_hi_d;
  logic [7:0] addr_lo_q, addr_lo_d;
  logic [7:0] wdata_q, wdata_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] rdata_q, rdata_d;
  logic       err_q, err_d;

  logic [7:0] bus_out_q, bus_out_d;
  logic       bus_oe_q, bus_oe_d;
  logic       ale_hi_q, ale_hi_d;
  logic       ale_lo_q, ale_lo_d;
  logic       oe_n_q, oe_n_d;
  logic       we_n_q, we_n_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Transfer sequencing; request fields are captured only when leaving IDLE.
  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    addr_hi_d  = addr_hi_q;
    addr_lo_d  = addr_lo_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          rw_d      = bus.rw;
          addr_hi_d = bus.addr_hi;
          addr_lo_d = bus.addr_lo;
          wdata_d   = bus.wdata;
          err_d     = 1'b0;
          state_d   = ADDR_H;
        end
      end
      ADDR_H: state_d = ADDR_L;
      ADDR_L: begin
        wait_cnt_d = 4'd0;
        state_d    = DATA;
      end
      DATA: begin
        if (bus.mem_rdy) begin
          if (!rw_q) begin
            rdata_d = bus.bus_in;
          end
          state_d = DONE;
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the next state so they line up with the state they describe.
  always_comb begin
    bus_out_d = 8'h00;
    bus_oe_d  = 1'b0;
    ale_hi_d  = 1'b0;
    ale_lo_d  = 1'b0;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    case (state_d)
      ADDR_H: begin
        bus_out_d = addr_hi_d;
        bus_oe_d  = 1'b1;
        ale_hi_d  = 1'b1;
      end
      ADDR_L: begin
        bus_out_d = addr_lo_d;
        bus_oe_d  = 1'b1;
        ale_lo_d  = 1'b1;
      end
      DATA: begin
        if (rw_d) begin
          bus_out_d = wdata_d;
          bus_oe_d  = 1'b1;
          we_n_d    = 1'b0;
        end else begin
          oe_n_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rw_q       <= 1'b0;
      addr_hi_q  <= 8'h00;
      addr_lo_q  <= 8'h00;
      wdata_q    <= 8'h00;
      wait_cnt_q <= 4'd0;
      rdata_q    <= 8'h00;
      err_q      <= 1'b0;
      bus_out_q  <= 8'h00;
      bus_oe_q   <= 1'b0;
      ale_hi_q   <= 1'b0;
      ale_lo_q   <= 1'b0;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      addr_hi_q  <= addr_hi_d;
      addr_lo_q  <= addr_lo_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      bus_out_q  <= bus_out_d;
      bus_oe_q   <= bus_oe_d;
      ale_hi_q   <= ale_hi_d;
      ale_lo_q   <= ale_lo_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.bus_out = bus_out_q;
  assign bus.bus_oe  = bus_oe_q;
  assign bus.ale_hi  = ale_hi_q;
  assign bus.ale_lo  = ale_lo_q;
  assign bus.oe_n    = oe_n_q;
  assign bus.we_n    = we_n_q;
  assign bus.rdata   = rdata_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_bus_interface_unit.sv
// Testbench for bus_interface_unit: directed vector table, randomized transfers against a
// phase-timing reference model, and an asynchronous reset abort during a write.
module tb_bus_interface_unit;

  localparam int WM = 6;

  logic clk = 1'b0;
  logic rst_n;

  bus_interface_unit_if bif ();

  bus_interface_unit #(.WAIT_MAX(WM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic       rw;
    logic [7:0] ah;
    logic [7:0] al;
    logic [7:0] wd;
    logic [7:0] bus_in;
    int         waits;
    logic       keep_req;
    int         exp_done;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  // Observed tuple: {bus_out, bus_oe, ale_hi, ale_lo, oe_n, we_n, busy, done}
  logic [14:0] obs;
  assign obs = {bif.bus_out, bif.bus_oe, bif.ale_hi, bif.ale_lo,
                bif.oe_n, bif.we_n, bif.busy, bif.done};

  localparam logic [14:0] IDLE_T = {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  // Expected bus tuple for cycle n after the accepting edge, from the phase timeline only.
  function automatic logic [14:0] exp_cycle(int n, int done_edge, logic rw,
                                            logic [7:0] ah, logic [7:0] al, logic [7:0] wd);
    if (n == 1) return {ah, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    if (n == 2) return {al, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    if (n == done_edge) return {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    if (rw) return {wd, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    return {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  endfunction

  function automatic int model_done(int waits);
    return 3 + ((waits > WM) ? (WM + 1) : (waits + 1));
  endfunction

  task automatic checkOutput(input string name, input logic [14:0] act, input logic [14:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one transfer starting from a negedge with the unit idle; returns at a negedge.
  task automatic applyStimulus(input vec_t v, input string tag);
    bif.req     = 1'b1;
    bif.rw      = v.rw;
    bif.addr_hi = v.ah;
    bif.addr_lo = v.al;
    bif.wdata   = v.wd;
    bif.bus_in  = v.bus_in;
    bif.mem_rdy = 1'b0;
    @(posedge clk);
    #1;
    bif.req     = v.keep_req;
    bif.addr_hi = 8'($urandom);
    bif.addr_lo = 8'($urandom);
    bif.wdata   = 8'($urandom);
    for (int n = 1; n <= v.exp_done; n++) begin
      @(negedge clk);
      checkOutput($sformatf("%s cycle%0d", tag, n), obs,
                  exp_cycle(n, v.exp_done, v.rw, v.ah, v.al, v.wd));
      bif.mem_rdy = (n >= 3 + v.waits);
      @(posedge clk);
    end
    @(negedge clk);
    bif.mem_rdy = 1'b0;
    checkOutput({tag, " idleAfter"}, obs, IDLE_T);
    checkOutput({tag, " rdata"}, {7'b0, bif.rdata}, {7'b0, v.exp_rdata});
    checkOutput({tag, " err"}, {14'b0, bif.err}, {14'b0, v.exp_err});
  endtask

  vec_t vecs[8];
  vec_t rv;
  logic [7:0] rdata_model;

  initial begin
    rst_n       = 1'b0;
    bif.req     = 1'b0;
    bif.rw      = 1'b0;
    bif.addr_hi = 8'h00;
    bif.addr_lo = 8'h00;
    bif.wdata   = 8'h00;
    bif.bus_in  = 8'h00;
    bif.mem_rdy = 1'b0;

    //           rw    ah     al     wd     bus_in waits keep  done rdata  err
    vecs[0] = '{1'b0, 8'h12, 8'h34, 8'h00, 8'hA5, 0, 1'b0, 4,  8'hA5, 1'b0};
    vecs[1] = '{1'b1, 8'h56, 8'h78, 8'h5C, 8'h3C, 3, 1'b0, 7,  8'hA5, 1'b0};
    vecs[2] = '{1'b0, 8'h9A, 8'hBC, 8'h00, 8'h77, 8, 1'b0, 10, 8'hA5, 1'b1};
    vecs[3] = '{1'b0, 8'h01, 8'h02, 8'h00, 8'h4E, 0, 1'b0, 4,  8'h4E, 1'b0};
    vecs[4] = '{1'b0, 8'hFF, 8'h00, 8'h00, 8'h11, 6, 1'b0, 10, 8'h11, 1'b0};
    vecs[5] = '{1'b1, 8'h80, 8'h7F, 8'hC9, 8'h22, 7, 1'b0, 10, 8'h11, 1'b1};
    vecs[6] = '{1'b0, 8'h33, 8'h44, 8'h00, 8'hC3, 1, 1'b1, 5,  8'hC3, 1'b0};
    vecs[7] = '{1'b1, 8'h55, 8'h66, 8'hAA, 8'h00, 0, 1'b0, 4,  8'hC3, 1'b0};

    repeat (2) @(negedge clk);
    checkOutput("reset outputs", obs, IDLE_T);
    checkOutput("reset rdata", {7'b0, bif.rdata}, 15'h0);
    checkOutput("reset err", {14'b0, bif.err}, 15'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    rdata_model = vecs[7].exp_rdata;
    for (int i = 0; i < 20; i++) begin
      rv.rw       = 1'($urandom_range(0, 1));
      rv.ah       = 8'($urandom);
      rv.al       = 8'($urandom);
      rv.wd       = 8'($urandom);
      rv.bus_in   = 8'($urandom);
      rv.waits    = int'($urandom_range(0, WM + 2));
      rv.keep_req = 1'($urandom_range(0, 1));
      rv.exp_done = model_done(rv.waits);
      if (!rv.rw && rv.waits <= WM) rdata_model = rv.bus_in;
      rv.exp_rdata = rdata_model;
      rv.exp_err   = (rv.waits > WM);
      applyStimulus(rv, $sformatf("rnd%0d", i));
    end
    bif.req = 1'b0;

    // Abort a write in its data phase with an asynchronous reset.
    bif.req     = 1'b1;
    bif.rw      = 1'b1;
    bif.addr_hi = 8'hAB;
    bif.addr_lo = 8'hCD;
    bif.wdata   = 8'hE7;
    bif.mem_rdy = 1'b0;
    @(posedge clk);
    #1;
    bif.req = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort preWrite", obs, exp_cycle(3, 99, 1'b1, 8'hAB, 8'hCD, 8'hE7));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort async", obs, IDLE_T);
    checkOutput("abort rdata", {7'b0, bif.rdata}, 15'h0);
    checkOutput("abort err", {14'b0, bif.err}, 15'h0);
    bif.mem_rdy = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("abort hold", obs, IDLE_T);
    end
    bif.mem_rdy = 1'b0;
    rst_n       = 1'b1;
    rv = '{1'b0, 8'h21, 8'h43, 8'h00, 8'h96, 0, 1'b0, 4, 8'h96, 1'b0};
    applyStimulus(rv, "postReset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_interface_unit.md
BUS_INTERFACE_UNIT -- requirements
Module: bus_interface_unit

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15, the maximum DATA-phase wait cycles before timeout (range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req, input, 1, the core transfer request, sampled only in IDLE.
REQ-005 SHALL have port rw, input, 1, transfer direction: low = read, high = write.
REQ-006 SHALL have port addr_hi, input, 8, the address high byte.
REQ-007 SHALL have port addr_lo, input, 8, the address low byte.
REQ-008 SHALL have port wdata, input, 8, the write data.
REQ-009 SHALL have port bus_in, input, 8, the external multiplexed bus read value.
REQ-010 SHALL have port mem_rdy, input, 1, the external memory ready; high completes the DATA phase.
REQ-011 SHALL have port bus_out, output, 8, the multiplexed address/data drive value.
REQ-012 SHALL have port bus_oe, output, 1, high when bus_out drives the pins.
REQ-013 SHALL have port ale_hi, output, 1, the external latch strobe for the address high byte.
REQ-014 SHALL have port ale_lo, output, 1, the external latch strobe for the address low byte.
REQ-015 SHALL have port oe_n, output, 1, active-low memory output enable.
REQ-016 SHALL have port we_n, output, 1, active-low memory write enable.
REQ-017 SHALL have port rdata, output, 8, the last successfully read byte.
REQ-018 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-019 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-020 SHALL have port err, output, 1, the timeout flag of the most recent transfer.

Function
REQ-021 SHALL implement the states IDLE, ADDR_H, ADDR_L, DATA and DONE, with all outputs registered or decoded from the state register only, so there is no combinational input-to-output path.
REQ-022 SHALL, in IDLE with req=1, latch rw, addr_hi, addr_lo and wdata, clear err, and move to ADDR_H; IDLE with req=0 stays in IDLE.
REQ-023 SHALL ignore req in every state other than IDLE, so latched transfer fields stay stable for the whole transfer.
REQ-024 SHALL, in ADDR_H, drive bus_out=addr_hi with bus_oe=1 and ale_hi=1 for exactly one cycle, then move to ADDR_L.
REQ-025 SHALL, in ADDR_L, drive bus_out=addr_lo with bus_oe=1 and ale_lo=1 for exactly one cycle, then move to DATA.
REQ-026 SHALL, in a DATA read, drive bus_oe=0 and oe_n=0; in a DATA write, drive bus_out=wdata, bus_oe=1 and we_n=0.
REQ-027 SHALL clear the 4-bit wait counter on entry to DATA and increment it on every DATA cycle that has mem_rdy=0.
REQ-028 SHALL, when mem_rdy=1 in DATA, capture bus_in into rdata (reads only) at that edge and move to DONE.
REQ-029 SHALL, when the wait counter equals WAIT_MAX with mem_rdy=0, set err=1, leave rdata unchanged and move to DONE; mem_rdy=1 on that same cycle takes priority and completes normally.
REQ-030 SHALL, in DONE, assert done=1 for one cycle with all strobes inactive and bus_oe=0, then return to IDLE.
REQ-031 SHALL hold err until the next accepted req.
REQ-032 SHALL give a zero-wait transfer done=1 on the 4th rising edge after the edge that accepted req; each mem_rdy-low cycle adds one.
REQ-033 SHALL keep the inactive level of every strobe (ale_hi=0, ale_lo=0, oe_n=1, we_n=1) in every state that does not assert it.
REQ-034 SHALL drive bus_out=0 whenever bus_oe=0.

Reset
REQ-035 SHALL, on rst_n low, immediately and asynchronously force state=IDLE, bus_out=0, bus_oe=0, ale_hi=0, ale_lo=0, oe_n=1, we_n=1, rdata=0, busy=0, done=0, err=0 and wait counter=0.
REQ-036 SHALL, on reset mid-transfer (including DATA write), drop we_n high without waiting for a clock edge; the aborted transfer produces no done pulse.
REQ-037 SHALL accept a new req on the first rising edge after rst_n deasserts.

Verification
REQ-038 Zero-wait read: req=1, rw=0, addr=0x12/0x34, mem_rdy=1, bus_in=0xA5 -> ale_hi with bus_out=0x12, ale_lo with bus_out=0x34, oe_n low for 1 cycle, done pulse at edge 4, rdata=0xA5, err=0.
REQ-039 Write with 3 wait cycles: rw=1, wdata=0x5C, mem_rdy low 3 cycles -> we_n low 4 cycles with bus_out=0x5C and bus_oe=1, done at edge 7.
REQ-040 Timeout: mem_rdy held 0 -> done at edge 4+WAIT_MAX, err=1, rdata keeps its previous value; next req clears err.
REQ-041 Back-to-back: req held high -> second transfer accepted in the IDLE cycle after DONE; addr changes while busy are ignored.
REQ-042 Reset during DATA write -> we_n=1 and bus_oe=0 asynchronously, no done, and a new read completes normally afterwards.
